weight_load_ctrl: RTL and testbench

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

---
 rtl/weight_load_ctrl_pkg.sv | 21 ++
 rtl/wl_addr_counter.sv | 67 ++++++
 rtl/weight_load_ctrl.sv | 131 +++++++++++++
 tb/tb_weight_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_load_ctrl_pkg.sv
// Shared definitions for the weight load controller.
//   Tn, Tm       : default buffer count and kernel words per buffer
//   wl_state_e   : load FSM state encoding
//   clamp_tm     : maps a requested kernel count onto the usable range 1..tm
package weight_load_ctrl_pkg;

  localparam int unsigned Tn = 4;
  localparam int unsigned Tm = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } wl_state_e;

  // 0 and anything above tm select the full buffer depth.
  function automatic int unsigned clamp_tm(int unsigned cfg, int unsigned tm);
    return ((cfg == 0) || (cfg > tm)) ? tm : cfg;
  endfunction

endpackage

// File: rtl/wl_addr_counter.sv
// Buffer/kernel address counter pair for the weight loader.
// Kernel index runs 0..limit-1 inside a buffer, then wraps and advances the buffer index.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero both indices (takes priority over inc)
//   inc        : advance by one beat
//   limit      : effective kernels per buffer (1..TM)
//   kernel_idx : current kernel word index
//   buf_idx    : current buffer index
//   last       : current position is the final word of the final buffer
module wl_addr_counter #(
  parameter int unsigned TN = 4,
  parameter int unsigned TM = 16,
  localparam int unsigned KernW = $clog2(TM),
  localparam int unsigned BufW = $clog2(TN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [KernW:0]   limit,
  output logic [KernW-1:0] kernel_idx,
  output logic [BufW-1:0]  buf_idx,
  output logic             last
);

  localparam logic [KernW:0] LimitOne = (KernW + 1)'(1);

  logic [KernW-1:0] kernel_q, kernel_d;
  logic [BufW-1:0]  buf_q, buf_d;
  logic             kernel_wrap;
  logic             buf_last;

  assign kernel_wrap = ({1'b0, kernel_q} == (limit - LimitOne));
  assign buf_last    = (buf_q == BufW'(TN - 1));

  always_comb begin
    kernel_d = kernel_q;
    buf_d    = buf_q;
    if (clr) begin
      kernel_d = '0;
      buf_d    = '0;
    end else if (inc) begin
      if (kernel_wrap) begin
        kernel_d = '0;
        buf_d    = buf_last ? '0 : buf_q + BufW'(1);
      end else begin
        kernel_d = kernel_q + KernW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kernel_q <= '0;
      buf_q    <= '0;
    end else begin
      kernel_q <= kernel_d;
      buf_q    <= buf_d;
    end
  end

  assign kernel_idx = kernel_q;
  assign buf_idx    = buf_q;
  assign last       = kernel_wrap && buf_last;

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight load controller: streams TN*eff_tm words into a flat buffer array,
// kernel-major within each buffer, with a one-cycle registered write port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, cfg_tm     : load request and kernels per buffer (0 or >TM means TM)
//   w_valid, w_data   : input stream; w_ready high only while loading
//   wb_wea/addra/dia  : buffer write port, addr = {1'b0, buf_idx, kernel_idx}
//   busy, done        : load in progress / one-cycle completion pulse
//   checksum          : XOR of words written this load
// Build option: define WEIGHT_LOAD_CHECKSUM_EN to enable the checksum accumulator;
// otherwise checksum is tied to zero.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int unsigned TN = Tn,
  parameter int unsigned TM = Tm,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned ADDR_WIDTH = $clog2(TM),
  localparam int unsigned ADDR_EXT = $clog2(TN) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH:0]            cfg_tm,
  input  logic                           w_valid,
  input  logic [DATA_WIDTH-1:0]          w_data,
  output logic                           w_ready,
  output logic                           wb_wea,
  output logic [ADDR_EXT+ADDR_WIDTH-1:0] wb_addra,
  output logic [DATA_WIDTH-1:0]          wb_dia,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          checksum
);

  localparam int unsigned BufW = ADDR_EXT - 1;

  wl_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] eff_tm_q, eff_tm_d;

  logic                  start_acc;
  logic                  beat_acc;
  logic                  cnt_last;
  logic [ADDR_WIDTH-1:0] kernel_idx;
  logic [BufW-1:0]       buf_idx;

  logic                           wea_q;
  logic [ADDR_EXT+ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]          dia_q;

  assign start_acc = (state_q == StIdle) && start;
  assign beat_acc  = (state_q == StLoad) && w_valid;

  wl_addr_counter #(
    .TN(TN),
    .TM(TM)
  ) u_addr_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .inc       (beat_acc),
    .limit     (eff_tm_q),
    .kernel_idx(kernel_idx),
    .buf_idx   (buf_idx),
    .last      (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    eff_tm_d = eff_tm_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          eff_tm_d = (ADDR_WIDTH + 1)'(clamp_tm(int'(cfg_tm), TM));
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (beat_acc && cnt_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      eff_tm_q <= (ADDR_WIDTH + 1)'(TM);
      wea_q    <= 1'b0;
      addr_q   <= '0;
      dia_q    <= '0;
    end else begin
      state_q  <= state_d;
      eff_tm_q <= eff_tm_d;
      wea_q    <= beat_acc;
      if (beat_acc) begin
        addr_q <= {1'b0, buf_idx, kernel_idx};
        dia_q  <= w_data;
      end
    end
  end

  // Final write is presented in the DONE cycle, so w_ready is already low then.
  assign w_ready  = (state_q == StLoad);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign wb_wea   = wea_q;
  assign wb_addra = addr_q;
  assign wb_dia   = dia_q;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // Accumulates on accept, so the value already covers the word on the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start_acc) begin
      csum_q <= '0;
    end else if (beat_acc) begin
      csum_q <= csum_q ^ w_data;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl (TN=4, TM=16, DATA_WIDTH=64).
module tb_weight_load_ctrl;

  localparam int TN = 4;
  localparam int TM = 16;
  localparam int DW = 64;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  localparam bit CsumOn = 1'b1;
`else
  localparam bit CsumOn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [4:0]    cfg_tm;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          wb_wea;
  logic [6:0]    wb_addra;
  logic [DW-1:0] wb_dia;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  weight_load_ctrl #(
    .TN(TN),
    .TM(TM),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cfg_tm  (cfg_tm),
    .w_valid (w_valid),
    .w_data  (w_data),
    .w_ready (w_ready),
    .wb_wea  (wb_wea),
    .wb_addra(wb_addra),
    .wb_dia  (wb_dia),
    .busy    (busy),
    .done    (done),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a load is a count of accepted beats n against TN*eff;
  // beat n lands at buffer n/eff, kernel n%eff one cycle after acceptance.
  int          phase = 0;  // 0 idle, 1 loading, 2 done pulse
  int          eff = TM;
  int          n = 0;
  logic [63:0] m_csum = '0;
  logic        exp_ready, exp_wea, exp_busy, exp_done;
  logic [6:0]  exp_addr;
  logic [63:0] exp_data, exp_csum;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; n = 0; m_csum = '0;
      exp_ready = 0; exp_wea = 0; exp_busy = 0; exp_done = 0;
      exp_addr = '0; exp_data = '0; exp_csum = '0;
      model_ok = 1'b1;
    end else begin
      exp_wea = 1'b0;
      case (phase)
        0: if (start) begin
          eff = (cfg_tm == 0 || int'(cfg_tm) > TM) ? TM : int'(cfg_tm);
          n = 0;
          m_csum = '0;
          phase = 1;
        end
        1: if (w_valid) begin
          exp_wea  = 1'b1;
          exp_addr = 7'((n / eff) * TM + (n % eff));
          exp_data = w_data;
          m_csum   = m_csum ^ w_data;
          n++;
          if (n == TN * eff) phase = 2;
        end
        default: phase = 0;
      endcase
      exp_ready = (phase == 1);
      exp_busy  = (phase != 0);
      exp_done  = (phase == 2);
      exp_csum  = CsumOn ? m_csum : 64'd0;
    end
  end

  // Per-cycle compare plus a log of observed writes and done pulses.
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  logic [63:0] done_csum = '0;
  logic [6:0]  wr_addr_q[$];

  always @(negedge clk) begin
    cyc++;
    if (model_ok) begin
      chk("w_ready", 64'(w_ready), 64'(exp_ready));
      chk("wb_wea", 64'(wb_wea), 64'(exp_wea));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("checksum", checksum, exp_csum);
      if (exp_wea) begin
        chk("wb_addra", 64'(wb_addra), 64'(exp_addr));
        chk("wb_dia", wb_dia, exp_data);
      end
    end
    if (wb_wea === 1'b1) wr_addr_q.push_back(wb_addra);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_csum = checksum;
    end
    if (start === 1'b1 && !rst && !exp_busy) start_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] cfg);
    start  = 1'b1;
    cfg_tm = cfg;
    tick();
    start  = 1'b0;
  endtask

  task automatic beat(input logic [63:0] data, input logic valid);
    w_valid = valid;
    w_data  = data;
    tick();
  endtask

  task automatic idle(input int cycles);
    w_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  int q0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; cfg_tm = '0; w_valid = 1'b0; w_data = '0;
    repeat (2) tick();
    chk("rst_wea", 64'(wb_wea), 64'd0);
    chk("rst_addra", 64'(wb_addra), 64'd0);
    chk("rst_dia", wb_dia, 64'd0);
    chk("rst_ready", 64'(w_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_csum", checksum, 64'd0);
    rst = 1'b0;
    tick();

    // Full depth, back-to-back beats, data = index.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd0);
    for (int i = 0; i < 64; i++) beat(64'(i), 1'b1);
    idle(4);
    chk("t1_writes", 64'(wr_addr_q.size() - q0), 64'd64);
    chk("t1_addr17", 64'(wr_addr_q[q0 + 17]), 64'h11);
    chk("t1_addr63", 64'(wr_addr_q[q0 + 63]), 64'h3f);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_done_cycle", 64'(done_cyc - start_cyc + 1), 64'd66);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Five kernels per buffer.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd5);
    for (int i = 0; i < 20; i++) beat(64'(100 + i), 1'b1);
    idle(3);
    chk("t2_writes", 64'(wr_addr_q.size() - q0), 64'd20);
    chk("t2_addr4", 64'(wr_addr_q[q0 + 4]), 64'h04);
    chk("t2_addr5", 64'(wr_addr_q[q0 + 5]), 64'h10);
    chk("t2_addr19", 64'(wr_addr_q[q0 + 19]), 64'h34);
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

    // w_valid on alternate cycles.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd2);
    for (int i = 0; i < 16; i++) beat(64'(32'hA000 + i), (i % 2) == 0);
    idle(3);
    chk("t3_writes", 64'(wr_addr_q.size() - q0), 64'd8);
    chk("t3_addr2", 64'(wr_addr_q[q0 + 2]), 64'h10);
    chk("t3_addr7", 64'(wr_addr_q[q0 + 7]), 64'h31);
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Reset after ten beats, then restart.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd0);
    for (int i = 0; i < 10; i++) beat(64'(i + 7), 1'b1);
    rst = 1'b1;
    beat(64'hdead, 1'b1);
    chk("t4_wea_after_rst", 64'(wb_wea), 64'd0);
    rst = 1'b0;
    idle(3);
    chk("t4_writes", 64'(wr_addr_q.size() - q0), 64'd10);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd3);
    for (int i = 0; i < 12; i++) beat(64'(i), 1'b1);
    idle(3);
    chk("t4_restart_addr0", 64'(wr_addr_q[q0]), 64'h00);
    chk("t4_restart_writes", 64'(wr_addr_q.size() - q0), 64'd12);
    chk("t4_restart_done", 64'(done_cnt - d0), 64'd1);

    // start pulsed mid-load is ignored.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd4);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        start = 1'b1;
        cfg_tm = 5'd2;
      end
      beat(64'(i * 3), 1'b1);
      start = 1'b0;
    end
    idle(3);
    chk("t5_writes", 64'(wr_addr_q.size() - q0), 64'd16);
    chk("t5_addr6", 64'(wr_addr_q[q0 + 6]), 64'h12);
    chk("t5_addr15", 64'(wr_addr_q[q0 + 15]), 64'h33);
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Checksum over 1,2,4,8 with one kernel per buffer.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd1);
    beat(64'h1, 1'b1);
    beat(64'h2, 1'b1);
    beat(64'h4, 1'b1);
    beat(64'h8, 1'b1);
    idle(3);
    chk("t6_writes", 64'(wr_addr_q.size() - q0), 64'd4);
    chk("t6_addr3", 64'(wr_addr_q[q0 + 3]), 64'h30);
    chk("t6_done_csum", done_csum, CsumOn ? 64'hf : 64'h0);
    chk("t6_csum_held", checksum, CsumOn ? 64'hf : 64'h0);

    // cfg_tm above TM selects full depth.
    q0 = wr_addr_q.size(); d0 = done_cnt;
    do_start(5'd20);
    for (int i = 0; i < 64; i++) beat(64'(i ^ 55), 1'b1);
    idle(3);
    chk("t7_writes", 64'(wr_addr_q.size() - q0), 64'd64);
    chk("t7_addr16", 64'(wr_addr_q[q0 + 16]), 64'h10);
    chk("t7_done_cnt", 64'(done_cnt - d0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
